mem_stage_sequencer: RTL and testbench

Parametrised memory-stage access sequencer for the pipelined LC-3b datapath, the next-generation replacement for the MEM-stage stall unit. It sits between the EX/MEM pipeline register and the data-side cache port. It sequences single and indirect (LDI/STI) accesses and holds the returned read word. It raises `stall_pipeline` until both the data access and the concurrent instruction fetch have completed, and keeps a saturating stall-cycle counter for performance analysis.

---
 rtl/mem_stage_sequencer.sv | 158 +++++++++++++++
 tb/tb_mem_stage_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sequencer.sv
// MEM-stage access sequencer: single and indirect data accesses,
// read-word hold, pipeline stall generation and stall-cycle counter.
module mem_stage_sequencer #(
  parameter int ADDR_W = 12,
  parameter int OFF_W  = 4,
  parameter int WORD_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              is_ldi,
  input  logic              is_sti,
  input  logic [ADDR_W-1:0] mem_address_in,
  input  logic [OFF_W-1:0]  line_offset_in,
  input  logic [WORD_W-1:0] mem_rdata_word,
  input  logic              mem_resp,
  input  logic              ifetch_resp,
  input  logic              clr_count,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [OFF_W-1:0]  line_offset_out,
  output logic              stall_pipeline,
  output logic [WORD_W-1:0] rdata_hold,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    IDLE,
    PTR,
    ACC,
    DONE
  } state_t;

  state_t            state_q;
  logic              rd_q;
  logic              wr_q;
  logic              if_done_q;
  logic              if_done_d;
  logic [WORD_W-1:0] ptr_q;
  logic [WORD_W-1:0] hold_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              req;
  logic              ind;
  logic              if_ok;
  logic              stall;
  logic              use_ptr;

  assign req   = mem_read_in | mem_write_in;
  assign ind   = is_ldi | is_sti;
  assign if_ok = ifetch_resp | if_done_q;

  // Stall whenever an access is pending or the fetch has not finished.
  always_comb begin
    stall = 1'b1;
    unique case (state_q)
      IDLE:    stall = req | ~if_ok;
      DONE:    stall = ~if_ok;
      default: stall = 1'b1;
    endcase
  end

  // Final access of an indirect op is addressed by the fetched pointer.
  assign use_ptr = ind & ((state_q == ACC) | (state_q == DONE));

  assign mem_address     = use_ptr ? ptr_q[WORD_W-1:OFF_W] : mem_address_in;
  assign line_offset_out = use_ptr ? ptr_q[OFF_W-1:0] : line_offset_in;
  assign mem_read        = rd_q;
  assign mem_write       = wr_q;
  assign stall_pipeline  = stall;
  assign rdata_hold      = hold_q;
  assign stall_count     = cnt_q;

  // Access sequencing with strobes registered on state entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (ind) begin
              state_q <= PTR;
              rd_q    <= 1'b1;
              wr_q    <= 1'b0;
            end else begin
              state_q <= ACC;
              rd_q    <= mem_read_in;
              wr_q    <= mem_write_in;
            end
          end
        end
        PTR: begin
          if (mem_resp) begin
            ptr_q   <= mem_rdata_word;
            state_q <= ACC;
            rd_q    <= mem_read_in;
            wr_q    <= mem_write_in;
          end
        end
        ACC: begin
          if (mem_resp) begin
            if (mem_read_in) begin
              hold_q <= mem_rdata_word;
            end
            state_q <= DONE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
          end
        end
        DONE: begin
          if (if_ok) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  // Remember a fetch completion seen while the pipeline is frozen.
  always_comb begin
    if_done_d = if_done_q;
    if (!stall) begin
      if_done_d = 1'b0;
    end else if (ifetch_resp) begin
      if_done_d = 1'b1;
    end
  end

  // Saturating stall counter; clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_count) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Fetch flag and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_done_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if_done_q <= if_done_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Bench for mem_stage_sequencer: directed ops, reset mid-access,
// then randomized ops against a phase-timeline reference model.
module tb_mem_stage_sequencer;

  logic        clk;
  logic        reset;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        is_ldi;
  logic        is_sti;
  logic [11:0] mem_address_in;
  logic [3:0]  line_offset_in;
  logic [15:0] mem_rdata_word;
  logic        mem_resp;
  logic        ifetch_resp;
  logic        clr_count;

  logic        mem_read;
  logic        mem_write;
  logic [11:0] mem_address;
  logic [3:0]  line_offset_out;
  logic        stall_pipeline;
  logic [15:0] rdata_hold;
  logic [15:0] stall_count;

  logic        s_mem_read;
  logic        s_mem_write;
  logic [11:0] s_mem_address;
  logic [3:0]  s_line_offset_out;
  logic        s_stall_pipeline;
  logic [15:0] s_rdata_hold;
  logic [3:0]  s_stall_count;

  int compared;
  int mismatched;

  logic [15:0] exp_hold;
  int          exp_cnt;
  int          exp_scnt;
  bit          allow_clr;

  mem_stage_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .mem_read_in     (mem_read_in),
    .mem_write_in    (mem_write_in),
    .is_ldi          (is_ldi),
    .is_sti          (is_sti),
    .mem_address_in  (mem_address_in),
    .line_offset_in  (line_offset_in),
    .mem_rdata_word  (mem_rdata_word),
    .mem_resp        (mem_resp),
    .ifetch_resp     (ifetch_resp),
    .clr_count       (clr_count),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .line_offset_out (line_offset_out),
    .stall_pipeline  (stall_pipeline),
    .rdata_hold      (rdata_hold),
    .stall_count     (stall_count)
  );

  mem_stage_sequencer #(.CNT_W(4)) dut_sat (
    .clk             (clk),
    .reset           (reset),
    .mem_read_in     (mem_read_in),
    .mem_write_in    (mem_write_in),
    .is_ldi          (is_ldi),
    .is_sti          (is_sti),
    .mem_address_in  (mem_address_in),
    .line_offset_in  (line_offset_in),
    .mem_rdata_word  (mem_rdata_word),
    .mem_resp        (mem_resp),
    .ifetch_resp     (ifetch_resp),
    .clr_count       (clr_count),
    .mem_read        (s_mem_read),
    .mem_write       (s_mem_write),
    .mem_address     (s_mem_address),
    .line_offset_out (s_line_offset_out),
    .stall_pipeline  (s_stall_pipeline),
    .rdata_hold      (s_rdata_hold),
    .stall_count     (s_stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One memory op described by its phase lengths: 1 IDLE cycle,
  // lp pointer cycles (indirect only), la access cycles, then DONE
  // until the fetch has been seen. Cycle e is the only unstalled one.
  task automatic do_op(input bit rd, input bit ind,
                       input logic [11:0] a, input logic [3:0] o,
                       input logic [15:0] pw, input logic [15:0] dw,
                       input int lp_in, input int la, input int f);
    int lp, d0, e, rk;
    bit ptr_ph, acc_ph, done_ph, st, erd, ewr, clr;
    logic [11:0] ea;
    logic [3:0]  eo;
    lp = ind ? lp_in : 0;
    rk = lp + la;
    d0 = rk + 1;
    e  = (f > d0) ? f : d0;
    for (int k = 0; k <= e; k++) begin
      mem_read_in    = rd;
      mem_write_in   = !rd;
      is_ldi         = ind && rd;
      is_sti         = ind && !rd;
      mem_address_in = a;
      line_offset_in = o;
      ifetch_resp    = (k == f);
      clr            = allow_clr && ($urandom_range(0, 39) == 0);
      clr_count      = clr;
      mem_rdata_word = 16'($urandom);
      mem_resp       = 1'b0;
      if (ind && k == lp) begin
        mem_resp       = 1'b1;
        mem_rdata_word = pw;
      end else if (k == rk) begin
        mem_resp       = 1'b1;
        mem_rdata_word = dw;
      end else if (k == 0 || k >= d0) begin
        mem_resp = 1'($urandom_range(0, 1));
      end
      ptr_ph  = ind && k >= 1 && k <= lp;
      acc_ph  = k > lp && k <= rk;
      done_ph = k >= d0;
      erd     = ptr_ph || (acc_ph && rd);
      ewr     = acc_ph && !rd;
      if (ind && (acc_ph || done_ph)) begin
        ea = pw[15:4];
        eo = pw[3:0];
      end else begin
        ea = a;
        eo = o;
      end
      st = (k < e);
      @(negedge clk);
      chk("rd", mem_read, erd);
      chk("wr", mem_write, ewr);
      chk("addr", mem_address, ea);
      chk("off", line_offset_out, eo);
      chk("stall", stall_pipeline, st);
      chk("hold", rdata_hold, exp_hold);
      chk("cnt", stall_count, exp_cnt);
      chk("s_rd", s_mem_read, erd);
      chk("s_wr", s_mem_write, ewr);
      chk("s_addr", s_mem_address, ea);
      chk("s_off", s_line_offset_out, eo);
      chk("s_stall", s_stall_pipeline, st);
      chk("s_hold", s_rdata_hold, exp_hold);
      chk("s_cnt", s_stall_count, exp_scnt);
      @(posedge clk);
      if (k == rk && rd) exp_hold = dw;
      if (clr) begin
        exp_cnt  = 0;
        exp_scnt = 0;
      end else if (st) begin
        if (exp_cnt < 65535) exp_cnt++;
        if (exp_scnt < 15) exp_scnt++;
      end
      #1;
    end
  endtask

  initial begin
    bit rd, ind;
    int lp, la, f, d0;
    compared   = 0;
    mismatched = 0;
    exp_hold   = '0;
    exp_cnt    = 0;
    exp_scnt   = 0;
    allow_clr  = 0;
    reset          = 1'b1;
    mem_read_in    = 1'b0;
    mem_write_in   = 1'b0;
    is_ldi         = 1'b0;
    is_sti         = 1'b0;
    mem_address_in = '0;
    line_offset_in = '0;
    mem_rdata_word = '0;
    mem_resp       = 1'b0;
    ifetch_resp    = 1'b0;
    clr_count      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd", mem_read, 0);
    chk("rst_wr", mem_write, 0);
    chk("rst_stall", stall_pipeline, 1);
    chk("rst_hold", rdata_hold, 0);
    chk("rst_cnt", stall_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Direct read, data on 3rd access cycle, fetch done earlier.
    do_op(1, 0, 12'h123, 4'h4, 16'h0000, 16'hBEEF, 0, 3, 1);
    chk("dr_hold", rdata_hold, 16'hBEEF);
    chk("dr_cnt", stall_count, 4);
    // LDI through pointer 0x4A36.
    do_op(1, 1, 12'h321, 4'h1, 16'h4A36, 16'h5A5A, 2, 2, 3);
    chk("ldi_hold", rdata_hold, 16'h5A5A);
    // STI through pointer 0x1002; hold must not change.
    do_op(0, 1, 12'h0AA, 4'h3, 16'h1002, 16'h7777, 1, 1, 0);
    chk("sti_hold", rdata_hold, 16'h5A5A);
    // Late fetch: 4 cycles after data completion.
    do_op(0, 0, 12'h055, 4'h9, 16'h0000, 16'h1111, 0, 2, 7);
    // Fetch together with the final response.
    do_op(1, 0, 12'h077, 4'hE, 16'h0000, 16'h2222, 0, 2, 2);

    // Reset while in the pointer phase.
    mem_read_in    = 1'b1;
    mem_write_in   = 1'b0;
    is_ldi         = 1'b1;
    is_sti         = 1'b0;
    mem_address_in = 12'h444;
    line_offset_in = 4'h2;
    mem_resp       = 1'b0;
    ifetch_resp    = 1'b0;
    clr_count      = 1'b0;
    @(posedge clk);
    #1;
    chk("ptr_rd", mem_read, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_rd", mem_read, 0);
    chk("mrst_wr", mem_write, 0);
    chk("mrst_stall", stall_pipeline, 1);
    chk("mrst_cnt", stall_count, 0);
    chk("mrst_scnt", s_stall_count, 0);
    chk("mrst_hold", rdata_hold, 0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    exp_hold = '0;
    exp_cnt  = 0;
    exp_scnt = 0;

    // Randomized ops with occasional counter clears.
    allow_clr = 1;
    for (int n = 0; n < 200; n++) begin
      rd  = 1'($urandom_range(0, 1));
      ind = 1'($urandom_range(0, 1));
      lp  = $urandom_range(1, 3);
      la  = $urandom_range(1, 4);
      d0  = 1 + (ind ? lp : 0) + la;
      f   = $urandom_range(0, d0 + 4);
      do_op(rd, ind, 12'($urandom), 4'($urandom), 16'($urandom),
            16'($urandom), lp, la, f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
